// File: rtl/mips_pkg.sv
// Shared fetch-path definitions: fetch FSM states, PC step, redirect-select encoding.
package mips_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  typedef enum logic [1:0] {
    FS_FETCH = 2'd0,
    FS_WAIT  = 2'd1,
    FS_HOLD  = 2'd2,
    FS_HALT  = 2'd3
  } fetch_state_e;

  typedef enum logic [1:0] {
    SEL_SEQ    = 2'd0,
    SEL_JUMP   = 2'd1,
    SEL_BRANCH = 2'd2
  } redir_sel_e;

  // Clear the byte-offset bits of an address.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
    return {a[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC selection: sequential pc + 4, or a jump/branch redirect (jump wins).
// Also flags a redirect whose raw target is not word-aligned; the target
// presented on next_pc_c always has its low two bits cleared.
module pc_next_sel
  import mips_pkg::*;
(
  input  logic [XLEN-1:0] pc,
  input  logic            jump_en,
  input  logic [XLEN-1:0] jump_target,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  output redir_sel_e      sel_c,
  output logic [XLEN-1:0] pc_plus4_c,
  output logic [XLEN-1:0] next_pc_c,
  output logic            misaligned_c
);

  logic [XLEN-1:0] raw_target;

  // Priority select of the redirect source.
  always_comb begin
    sel_c      = SEL_SEQ;
    raw_target = '0;
    if (jump_en) begin
      sel_c      = SEL_JUMP;
      raw_target = jump_target;
    end else if (branch_taken) begin
      sel_c      = SEL_BRANCH;
      raw_target = branch_target;
    end
  end

  assign pc_plus4_c   = pc + PC_STEP;
  assign misaligned_c = (sel_c != SEL_SEQ) && (raw_target[1:0] != 2'b00);
  assign next_pc_c    = (sel_c == SEL_SEQ) ? pc_plus4_c : word_align(raw_target);

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction fetch front end: owns the PC, issues imem reads, buffers one
// instruction for decode and applies jump/branch redirects.
// Optional feature macro: PCF_ALIGN_CHECK_EN (misaligned-target trap + HALT).
module pc_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            jump_en,
  input  logic [XLEN-1:0] jump_target,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  input  logic            stall,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            instr_valid,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  output logic [XLEN-1:0] instr_pc_plus4
`ifdef PCF_ALIGN_CHECK_EN
  ,
  output logic            fetch_fault
`endif
);

  fetch_state_e    state;
  logic [XLEN-1:0] pc;
  logic            redir_pending;
  logic [XLEN-1:0] redir_target;

  redir_sel_e      sel;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] next_pc;
  logic            misaligned;
  logic            redir_in;
  logic            redir_any;
  logic [XLEN-1:0] redir_pc;

  pc_next_sel u_next_sel (
    .pc            (pc),
    .jump_en       (jump_en),
    .jump_target   (jump_target),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .sel_c         (sel),
    .pc_plus4_c    (pc_plus4),
    .next_pc_c     (next_pc),
    .misaligned_c  (misaligned)
  );

  // A redirect arriving this cycle supersedes any stored one.
  assign redir_in  = (sel != SEL_SEQ);
  assign redir_any = redir_in || redir_pending;
  assign redir_pc  = redir_in ? next_pc : redir_target;

  // Request is a decode of the state register, suppressed while in reset.
  assign imem_req_valid = (state == FS_FETCH) && !rst;
  assign imem_req_addr  = pc;

`ifndef PCF_ALIGN_CHECK_EN
  logic unused_misaligned;
  assign unused_misaligned = misaligned;
`endif

  // Fetch FSM, PC register, redirect capture and instruction buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= FS_FETCH;
      pc             <= RESET_PC;
      instr_valid    <= 1'b0;
      instr          <= '0;
      instr_pc       <= '0;
      instr_pc_plus4 <= PC_STEP;
      redir_pending  <= 1'b0;
      redir_target   <= '0;
`ifdef PCF_ALIGN_CHECK_EN
      fetch_fault    <= 1'b0;
`endif
    end else begin
      if (redir_in) begin
        redir_pending <= 1'b1;
        redir_target  <= next_pc;
      end
      case (state)
        // Address is held until accepted even if a redirect arrives; the
        // stale response is then dropped in WAIT.
        FS_FETCH: begin
          if (imem_req_ready) state <= FS_WAIT;
        end
        FS_WAIT: begin
          if (imem_rsp_valid) begin
            if (redir_any) begin
              pc            <= redir_pc;
              redir_pending <= 1'b0;
              state         <= FS_FETCH;
            end else begin
              instr          <= imem_rsp_data;
              instr_pc       <= pc;
              instr_pc_plus4 <= pc_plus4;
              instr_valid    <= 1'b1;
              pc             <= pc_plus4;
              state          <= FS_HOLD;
            end
          end
        end
        FS_HOLD: begin
          if (redir_any) begin
            instr_valid   <= 1'b0;
            pc            <= redir_pc;
            redir_pending <= 1'b0;
            state         <= FS_FETCH;
          end else if (!stall) begin
            instr_valid <= 1'b0;
            state       <= FS_FETCH;
          end
        end
        default: begin
        end
      endcase
`ifdef PCF_ALIGN_CHECK_EN
      if (redir_in && misaligned) begin
        fetch_fault <= 1'b1;
        instr_valid <= 1'b0;
        state       <= FS_HALT;
      end
`endif
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Randomized bench for pc_fetch_unit with an in-order memory model and a
// stream-level reference: the presented instruction must always be the
// word at the address the program flow says comes next.
module tb_pc_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        jump_en, branch_taken, stall;
  logic [31:0] jump_target, branch_target;
  logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
  logic [31:0] imem_req_addr, imem_rsp_data;
  logic        instr_valid;
  logic [31:0] instr, instr_pc, instr_pc_plus4;
`ifdef PCF_ALIGN_CHECK_EN
  logic        fetch_fault;
`endif

  always #5 clk = ~clk;

  pc_fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .jump_en        (jump_en),
    .jump_target    (jump_target),
    .branch_taken   (branch_taken),
    .branch_target  (branch_target),
    .stall          (stall),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_pc_plus4 (instr_pc_plus4)
`ifdef PCF_ALIGN_CHECK_EN
    ,
    .fetch_fault    (fetch_fault)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int idle     = 0;
  int n_consumed = 0;

  // stimulus knobs (percent probabilities) and one-shot forces
  int ready_pct, rsp_pct, stall_pct, redir_pct, spur_pct;
  int ready_low  = 0;
  int stall_left = 0;
  logic        f_redir = 1'b0, f_jump = 1'b0, f_br = 1'b0;
  logic [31:0] f_jt = '0, f_bt = '0;

  // reference state
  logic [31:0] memq[$];
  logic [31:0] req_log[$];
  int          rise_cyc[$];
  logic [31:0] exp_pc;
  logic        prev_pend, prev_rsp, prev_iv, prev_redir;
  logic [31:0] prev_addr;

  function automatic logic [31:0] memword(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
  endfunction

  function automatic logic [31:0] rand_target();
    logic [31:0] t;
    t = $urandom;
    if ($urandom_range(7) == 0) t = 32'hFFFF_FFF0 | (t & 32'h0000_000F);
`ifdef PCF_ALIGN_CHECK_EN
    t[1:0] = 2'b00;
`endif
    return t;
  endfunction

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic set_mode(input int r, input int rs, input int st, input int rd, input int sp);
    ready_pct = r; rsp_pct = rs; stall_pct = st; redir_pct = rd; spur_pct = sp;
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1;
    jump_en = 1'b0; branch_taken = 1'b0; stall = 1'b0;
    jump_target = '0; branch_target = '0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    repeat (n) @(negedge clk);
    chk1 ("rst_req_valid", imem_req_valid, 1'b0);
    chk32("rst_req_addr",  imem_req_addr,  RST_PC);
    chk1 ("rst_instr_valid", instr_valid,  1'b0);
    chk32("rst_instr",     instr,          32'h0);
    chk32("rst_instr_pc",  instr_pc,       32'h0);
    chk32("rst_pc_plus4",  instr_pc_plus4, 32'h4);
`ifdef PCF_ALIGN_CHECK_EN
    chk1 ("rst_fault",     fetch_fault,    1'b0);
`endif
    rst = 1'b0;
    memq.delete(); req_log.delete(); rise_cyc.delete();
    exp_pc = RST_PC;
    prev_pend = 1'b1; prev_addr = RST_PC;
    prev_rsp = 1'b0; prev_iv = 1'b0; prev_redir = 1'b0;
    ready_low = 0; stall_left = 0; f_redir = 1'b0;
    cyc = 0; idle = 0;
  endtask

  // One clock: check this cycle's outputs, drive this cycle's inputs, advance the model.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (instr_valid) begin
      chk32("instr_pc",     instr_pc,       exp_pc);
      chk32("instr_data",   instr,          memword(exp_pc));
      chk32("instr_plus4",  instr_pc_plus4, exp_pc + 32'd4);
      chk1 ("no_req_hold",  imem_req_valid, 1'b0);
      idle = 0;
    end else begin
      idle++;
      if (idle > 200) begin
        n_checks++; n_fail++;
        $display("FAIL watchdog: no instr_valid for %0d cycles, required progress (cycle %0d)", idle, cyc);
        idle = 0;
      end
    end
    if (instr_valid && !prev_iv) begin
      chk1("rise_after_rsp", prev_rsp, 1'b1);
      rise_cyc.push_back(cyc);
    end
    if (prev_pend) begin
      chk1 ("req_stable_v", imem_req_valid, 1'b1);
      chk32("req_stable_a", imem_req_addr,  prev_addr);
    end
    if (prev_redir && prev_iv) chk1("drop_on_redir", instr_valid, 1'b0);
    if (imem_req_valid) chk32("req_aligned", {30'd0, imem_req_addr[1:0]}, 32'h0);

    if (ready_low > 0) begin
      imem_req_ready = 1'b0;
      ready_low--;
    end else begin
      imem_req_ready = (int'($urandom_range(99)) < ready_pct);
    end
    if (memq.size() > 0 && int'($urandom_range(99)) < rsp_pct) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = memword(memq.pop_front());
    end else if (memq.size() == 0 && int'($urandom_range(99)) < spur_pct) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = $urandom;
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
    stall = (stall_left > 0) || (int'($urandom_range(99)) < stall_pct);
    if (stall_left > 0) stall_left--;
    if (f_redir) begin
      jump_en = f_jump; jump_target = f_jt;
      branch_taken = f_br; branch_target = f_bt;
      f_redir = 1'b0;
    end else begin
      jump_en      = (int'($urandom_range(99)) < redir_pct);
      branch_taken = (int'($urandom_range(99)) < redir_pct);
      jump_target  = rand_target();
      branch_target = rand_target();
    end

    if (imem_req_valid && imem_req_ready) begin
      memq.push_back(imem_req_addr);
      req_log.push_back(imem_req_addr);
    end
    prev_pend  = imem_req_valid && !imem_req_ready;
    prev_addr  = imem_req_addr;
    prev_rsp   = imem_rsp_valid;
    prev_iv    = instr_valid;
    prev_redir = jump_en || branch_taken;
    if (jump_en)                   exp_pc = {jump_target[31:2], 2'b00};
    else if (branch_taken)         exp_pc = {branch_target[31:2], 2'b00};
    else if (instr_valid && !stall) begin
      exp_pc = exp_pc + 32'd4;
      n_consumed++;
    end
  endtask

  task automatic force_redir(input logic j, input logic [31:0] jt, input logic b, input logic [31:0] bt);
    f_redir = 1'b1; f_jump = j; f_jt = jt; f_br = b; f_bt = bt;
  endtask

  initial begin
    rst = 1'b1;
    set_mode(100, 100, 0, 0, 0);

    // sequential fetch, always ready, 1-cycle response
    do_reset(2);
    step();
    chk1 ("a_first_req_v", imem_req_valid, 1'b1);
    chk32("a_first_req_a", imem_req_addr,  32'h0);
    repeat (9) step();
    chk1("a_nreq", req_log.size() >= 3, 1'b1);
    if (req_log.size() >= 3) begin
      chk32("a_req0", req_log[0], 32'h0);
      chk32("a_req1", req_log[1], 32'h4);
      chk32("a_req2", req_log[2], 32'h8);
    end
    chk1("a_nrise", rise_cyc.size() >= 3, 1'b1);
    if (rise_cyc.size() >= 3) begin
      chk32("a_rise0",  32'(rise_cyc[0]), 32'd3);
      chk32("a_rise01", 32'(rise_cyc[1] - rise_cyc[0]), 32'd3);
      chk32("a_rise12", 32'(rise_cyc[2] - rise_cyc[1]), 32'd3);
    end

    // ready low for 4 cycles while requesting 0x4
    do_reset(2);
    repeat (3) step();
    ready_low = 4;
    for (int i = 0; i < 4; i++) begin
      step();
      chk1 ("b_hold_v", imem_req_valid, 1'b1);
      chk32("b_hold_a", imem_req_addr,  32'h4);
    end
    step();
    chk1("b_accepted", req_log.size() == 2, 1'b1);

    // stall 5 cycles in HOLD
    do_reset(2);
    repeat (2) step();
    stall_left = 5;
    for (int i = 0; i < 5; i++) begin
      step();
      chk1 ("c_iv",   instr_valid,    1'b1);
      chk32("c_pc",   instr_pc,       32'h0);
      chk1 ("c_noreq", imem_req_valid, 1'b0);
    end
    step();
    chk1("c_last_iv", instr_valid, 1'b1);
    step();
    chk1 ("c_resume_v", imem_req_valid, 1'b1);
    chk32("c_resume_a", imem_req_addr,  32'h4);

    // jump in WAIT; then jump+branch together in HOLD
    do_reset(2);
    step();
    force_redir(1'b1, 32'h100, 1'b0, 32'h0);
    step();
    step();
    chk1 ("d_iv_drop", instr_valid,    1'b0);
    chk1 ("d_req_v",   imem_req_valid, 1'b1);
    chk32("d_req_a",   imem_req_addr,  32'h100);
    step();
    chk1 ("d_iv_wait", instr_valid, 1'b0);
    force_redir(1'b1, 32'h200, 1'b1, 32'h300);
    step();
    chk1 ("d_iv_tgt", instr_valid, 1'b1);
    chk32("d_pc_tgt", instr_pc,    32'h100);
    step();
    chk1 ("d_iv_drop2", instr_valid,   1'b0);
    chk32("d_jwins_a",  imem_req_addr, 32'h200);
    repeat (2) step();
    chk32("d_pc_200", instr_pc, 32'h200);

    // jump near the top of the address space: PC wraps to 0
    do_reset(2);
    force_redir(1'b1, 32'hFFFF_FFF8, 1'b0, 32'h0);
    repeat (3) step();
    chk32("e_req_fff8", imem_req_addr, 32'hFFFF_FFF8);
    repeat (5) step();
    chk32("e_pc_fffc",  instr_pc,       32'hFFFF_FFFC);
    chk32("e_plus4_0",  instr_pc_plus4, 32'h0);
    step();
    chk1 ("e_wrap_v", imem_req_valid, 1'b1);
    chk32("e_wrap_a", imem_req_addr,  32'h0);

    // misaligned branch target 0x102
    do_reset(2);
    force_redir(1'b0, 32'h0, 1'b1, 32'h102);
`ifdef PCF_ALIGN_CHECK_EN
    repeat (2) step();
    chk1("f_fault", fetch_fault, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk1("f_noreq", imem_req_valid, 1'b0);
      chk1("f_noiv",  instr_valid,    1'b0);
    end
    do_reset(2);
    step();
    chk1 ("f_restart_v", imem_req_valid, 1'b1);
    chk32("f_restart_a", imem_req_addr,  RST_PC);
    chk1 ("f_fault_clr", fetch_fault,    1'b0);
`else
    repeat (3) step();
    chk32("f_forced_a", imem_req_addr, 32'h100);
`endif

    // randomized traffic with a mid-run reset
    set_mode(70, 60, 30, 4, 20);
    do_reset(2);
    n_consumed = 0;
    repeat (1500) step();
    do_reset(2);
    repeat (1500) step();
    chk1("r_progress", n_consumed > 200, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
